// File: rtl/distance_median_filter.sv
// Median-of-5 distance filter: sliding window, odd-even transposition sort,
// and a hysteretic too-close flag for the direction state machine.
module distance_median_filter #(
  parameter logic [7:0] TOO_CLOSE   = 8'd20,
  parameter logic [7:0] HYST        = 8'd4,
  parameter bit         ZERO_AS_FAR = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [7:0] distance,
  output logic       busy,
  output logic       out_valid,
  output logic [7:0] filtered_distance,
  output logic       too_close
);

  typedef enum logic [1:0] {IDLE = 2'd0, SORT = 2'd1, OUT = 2'd2} state_t;

  state_t     state, state_next;
  logic [7:0] win     [5];
  logic [7:0] win_upd [5];
  logic [7:0] a       [5];
  logic [7:0] a_pass  [5];
  logic [2:0] pass;
  logic       primed;
  logic [7:0] s;
  logic [8:0] clr_sum;
  logic [7:0] clr_th;
  logic       accept, sort_en, publish;

  // A missing echo reads as 0; treat it as "far" so it never trips too_close.
  always_comb begin
    s       = (ZERO_AS_FAR && distance == 8'd0) ? 8'd255 : distance;
    clr_sum = {1'b0, TOO_CLOSE} + {1'b0, HYST};
    clr_th  = clr_sum[8] ? 8'hFF : clr_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_valid && !busy) state_next = SORT;
      SORT:    if (pass == 3'd4) state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept  = (state == IDLE) && sample_valid && !busy;
    sort_en = (state == SORT);
    publish = (state == OUT);
  end

  // The first sample after reset fills the whole window so the median is defined at once.
  always_comb begin
    win_upd[0] = s;
    for (int i = 1; i < 5; i++) win_upd[i] = primed ? win[i-1] : s;
  end

  // Even passes pair (0,1),(2,3); odd passes pair (1,2),(3,4); pairs are disjoint.
  always_comb begin
    for (int i = 0; i < 5; i++) a_pass[i] = a[i];
    if (!pass[0]) begin
      if (a[0] > a[1]) begin a_pass[0] = a[1]; a_pass[1] = a[0]; end
      if (a[2] > a[3]) begin a_pass[2] = a[3]; a_pass[3] = a[2]; end
    end else begin
      if (a[1] > a[2]) begin a_pass[1] = a[2]; a_pass[2] = a[1]; end
      if (a[3] > a[4]) begin a_pass[3] = a[4]; a_pass[4] = a[3]; end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy              <= 1'b0;
      out_valid         <= 1'b0;
      filtered_distance <= 8'd0;
      too_close         <= 1'b1;
      primed            <= 1'b0;
      for (int i = 0; i < 5; i++) win[i] <= 8'd0;
    end else begin
      // busy stays high through the out_valid cycle, so that cycle drops samples too.
      busy      <= accept || (state != IDLE);
      out_valid <= publish;
      if (accept) begin
        primed <= 1'b1;
        for (int i = 0; i < 5; i++) win[i] <= win_upd[i];
      end
      if (publish) begin
        filtered_distance <= a[2];
        if (a[2] < TOO_CLOSE)    too_close <= 1'b1;
        else if (a[2] >= clr_th) too_close <= 1'b0;
      end
    end
  end

  // NOTE: the sort copy and pass counter are left unreset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      pass <= 3'd0;
      for (int i = 0; i < 5; i++) a[i] <= win_upd[i];
    end else if (sort_en) begin
      pass <= pass + 3'd1;
      for (int i = 0; i < 5; i++) a[i] <= a_pass[i];
    end
  end

endmodule

// File: tb/tb_distance_median_filter.sv
// Scoreboard bench for distance_median_filter: an independent window/median/
// hysteresis model pushes expected results, popped when out_valid pulses.
module tb_distance_median_filter;

  localparam logic [7:0] TC = 8'd20;
  localparam logic [7:0] HY = 8'd4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_valid;
  logic [7:0] distance;
  logic       busy;
  logic       out_valid;
  logic [7:0] filtered_distance;
  logic       too_close;

  distance_median_filter #(.TOO_CLOSE(TC), .HYST(HY), .ZERO_AS_FAR(1'b1)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .distance(distance),
    .busy(busy), .out_valid(out_valid), .filtered_distance(filtered_distance),
    .too_close(too_close)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] med;
    logic       tc;
  } exp_t;

  exp_t       sb [$];
  int         checks = 0;
  int         errors = 0;
  int         ov_count = 0;
  logic [7:0] m_win [5];
  bit         m_primed;
  logic       m_tc;

  function automatic logic [7:0] median5(input logic [7:0] w [5]);
    logic [7:0] t [5];
    logic [7:0] key;
    int j;
    for (int i = 0; i < 5; i++) t[i] = w[i];
    for (int i = 1; i < 5; i++) begin
      key = t[i];
      j = i - 1;
      while (j >= 0 && t[j] > key) begin
        t[j+1] = t[j];
        j--;
      end
      t[j+1] = key;
    end
    return t[2];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_win[i] = 8'd0;
    m_primed = 1'b0;
    m_tc = 1'b1;
  endtask

  task automatic model_push(input logic [7:0] d);
    logic [7:0] sv;
    exp_t e;
    sv = (d == 8'd0) ? 8'd255 : d;
    if (!m_primed) begin
      for (int i = 0; i < 5; i++) m_win[i] = sv;
      m_primed = 1'b1;
    end else begin
      for (int i = 4; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = sv;
    end
    e.med = median5(m_win);
    if (e.med < 8'd20) m_tc = 1'b1;
    else if (e.med >= 8'd24) m_tc = 1'b0;
    e.tc = m_tc;
    sb.push_back(e);
  endtask

  // One clock; outputs sampled 1 time unit after the edge and scoreboarded.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (out_valid === 1'b1) begin
      ov_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: got filtered=%0d too_close=%b, required no output",
                 filtered_distance, too_close);
      end else begin
        e = sb.pop_front();
        if (filtered_distance !== e.med || too_close !== e.tc) begin
          errors++;
          $display("FAIL result: got filtered=%0d too_close=%b, required filtered=%0d too_close=%b",
                   filtered_distance, too_close, e.med, e.tc);
        end
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    sample_valid = 1'b0;
    repeat (cycles) tick();
    reset = 1'b0;
    model_reset();
  endtask

  // Strobe one sample, then run until busy drops; optionally check latency and busy length.
  task automatic drive_and_run(input logic [7:0] d, input bit timing);
    int seen = -1;
    int busy_cnt = 0;
    bit done = 1'b0;
    model_push(d);
    sample_valid = 1'b1;
    distance = d;
    tick();
    sample_valid = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (out_valid === 1'b1 && seen < 0) seen = k;
      if (busy === 1'b1) busy_cnt++;
      else done = 1'b1;
      if (!done) tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL busy_timeout: busy still %b after 20 cycles, required 0", busy);
    end
    if (timing) begin
      checks++;
      if (seen != 6) begin
        errors++;
        $display("FAIL latency: out_valid seen at edge %0d after accept, required 6", seen);
      end
      checks++;
      if (busy_cnt != 7) begin
        errors++;
        $display("FAIL busy_length: busy high %0d cycles, required 7", busy_cnt);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (filtered_distance !== 8'd0) begin
      errors++;
      $display("FAIL %s_filtered: got %0d, required 0", tag, filtered_distance);
    end
    checks++;
    if (too_close !== 1'b1) begin
      errors++;
      $display("FAIL %s_too_close: got %b, required 1", tag, too_close);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_out_valid: got %b, required 0", tag, out_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: got %b, required 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    distance = 8'd0;
    do_reset(2);
    check_reset_outputs("reset");
    repeat (5) tick();
    check_reset_outputs("reset_hold");
  endtask

  task automatic test_priming();
    drive_and_run(8'd50, 1'b1);
  endtask

  task automatic test_spike();
    repeat (4) drive_and_run(8'd50, 1'b0);
    drive_and_run(8'd3, 1'b1);
    drive_and_run(8'd3, 1'b0);
    drive_and_run(8'd3, 1'b0);
  endtask

  task automatic test_hysteresis();
    logic [7:0] seq [12] = '{8'd22, 8'd22, 8'd24, 8'd24, 8'd24, 8'd22, 8'd22, 8'd22,
                             8'd23, 8'd19, 8'd19, 8'd19};
    do_reset(2);
    foreach (seq[i]) drive_and_run(seq[i], 1'b0);
  endtask

  task automatic test_busy_drop();
    int ov_before;
    do_reset(2);
    drive_and_run(8'd40, 1'b0);
    ov_before = ov_count;
    model_push(8'd40);
    sample_valid = 1'b1;
    distance = 8'd40;
    tick();
    sample_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      // Retry in mid-sort and again in the out_valid cycle; both must be dropped.
      sample_valid = (k == 3 || k == 6);
      distance = 8'd90;
      tick();
    end
    sample_valid = 1'b0;
    checks++;
    if (ov_count - ov_before != 1) begin
      errors++;
      $display("FAIL busy_drop_count: got %0d out_valid pulses, required 1", ov_count - ov_before);
    end
    drive_and_run(8'd90, 1'b0);
    drive_and_run(8'd90, 1'b0);
  endtask

  task automatic test_zero_and_abort();
    int ov_before;
    do_reset(2);
    drive_and_run(8'd0, 1'b1);
    ov_before = ov_count;
    sample_valid = 1'b1;
    distance = 8'd30;
    tick();
    sample_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check_reset_outputs("abort");
    repeat (10) tick();
    checks++;
    if (ov_count != ov_before) begin
      errors++;
      $display("FAIL abort_no_output: got %0d out_valid pulses, required 0", ov_count - ov_before);
    end
    drive_and_run(8'd30, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    sample_valid = 1'b0;
    distance = 8'd0;
    model_reset();
    test_reset();
    test_priming();
    test_spike();
    test_hysteresis();
    test_busy_drop();
    test_zero_and_abort();
    repeat (3) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results never produced, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
